fft_pingpong_ctrl: RTL and testbench

Sequencer for the double-buffered (ping-pong) RAM behind each CORDIC/butterfly FFT stage. It takes the butterfly-result valid strobe and produces:
- bank write enables and write pair-addresses,
- the opposite bank's read addresses and read strobe.

It also runs a FILL/STREAM/DRAIN state machine so a final frame can be flushed without further input. One instance per stage, parameterised by the bit position where the A/B pair bit is inserted.

---
 rtl/fft_pkg.sv | 19 +
 rtl/pair_addr_gen.sv | 34 +++
 rtl/fft_pingpong_ctrl.sv | 126 ++++++++++++
 tb/tb_fft_pingpong_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, ping-pong sequencer state type and pair-address helper.
//   ADDR_W_DEF / N_PAIRS_DEF : default RAM address width and butterfly pairs per frame
//   pp_state_t               : FILL / STREAM / DRAIN sequencer states
//   insert_bit()             : splice a select bit into a pair count at a given position
package fft_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int N_PAIRS_DEF = 512;

    typedef enum logic [1:0] {ST_FILL, ST_STREAM, ST_DRAIN} pp_state_t;

    // Bits of c at and above split move up by one; b lands at position split.
    function automatic logic [31:0] insert_bit(input logic [31:0] c, input int split, input logic b);
        logic [31:0] low_mask;
        low_mask = (32'd1 << split) - 32'd1;
        return ((c & ~low_mask) << 1) | (32'(b) << split) | (c & low_mask);
    endfunction

endpackage

// File: rtl/pair_addr_gen.sv
// pair_addr_gen: wrapping pair counter with A/B split-address formation.
//   i_clk, i_reset : clock, async active-low reset (count clears to 0)
//   inc            : advance the count; wraps to 0 after N_PAIRS-1
//   wrap           : count is at N_PAIRS-1 (the next inc wraps)
//   addr_a, addr_b : count with 0 / 1 inserted at bit SPLIT
module pair_addr_gen
    import fft_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int N_PAIRS = N_PAIRS_DEF,
    parameter int SPLIT   = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              inc,
    output logic              wrap,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b
);

    logic [ADDR_W-2:0] cnt;

    assign wrap   = cnt == (ADDR_W-1)'(N_PAIRS - 1);
    assign addr_a = ADDR_W'(insert_bit(32'(cnt), SPLIT, 1'b0));
    assign addr_b = ADDR_W'(insert_bit(32'(cnt), SPLIT, 1'b1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            cnt <= '0;
        else if (inc)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/fft_pingpong_ctrl.sv
// fft_pingpong_ctrl: ping-pong RAM sequencer for one FFT butterfly stage.
//   i_clk, i_reset             : clock, async active-low reset
//   i_wr_valid, i_flush        : butterfly pair valid, single-cycle drain request
//   o_we_b0/1, o_wr_addr_a/b   : bank write enables and sum/difference write addresses
//   o_rd_addr_a/b, o_rd_bank   : opposite-bank read addresses and the bank being read
//   o_rd_strobe                : read addresses valid this cycle
//   o_frame_done, o_drain_done : pulses at end of a written frame / end of a drain
//   o_err                      : sticky, a write arrived during DRAIN and was dropped
//   o_busy                     : not idle (state other than FILL or a partial frame)
module fft_pingpong_ctrl
    import fft_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_PAIRS  = N_PAIRS_DEF,
    parameter int WR_SPLIT = 2,
    parameter int RD_SPLIT = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_valid,
    input  logic              i_flush,
    output logic              o_we_b0,
    output logic              o_we_b1,
    output logic [ADDR_W-1:0] o_wr_addr_a,
    output logic [ADDR_W-1:0] o_wr_addr_b,
    output logic [ADDR_W-1:0] o_rd_addr_a,
    output logic [ADDR_W-1:0] o_rd_addr_b,
    output logic              o_rd_bank,
    output logic              o_rd_strobe,
    output logic              o_frame_done,
    output logic              o_drain_done,
    output logic              o_err,
    output logic              o_busy
);

    pp_state_t         state;
    logic              wr_bank, flush_pend;
    logic              wr_fire, rd_fire, wr_zero;
    logic              wr_wrap, rd_wrap;
    logic [ADDR_W-1:0] wa_a, wa_b, ra_a, ra_b;

    assign wr_fire = i_wr_valid && state != ST_DRAIN;
    assign rd_fire = (i_wr_valid && state == ST_STREAM) || state == ST_DRAIN;
    // The A address carries a 0 in the inserted bit, so it is zero exactly when the count is.
    assign wr_zero = wa_a == '0;

    pair_addr_gen #(.ADDR_W(ADDR_W), .N_PAIRS(N_PAIRS), .SPLIT(WR_SPLIT)) wr_gen (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .inc    (wr_fire),
        .wrap   (wr_wrap),
        .addr_a (wa_a),
        .addr_b (wa_b)
    );

    pair_addr_gen #(.ADDR_W(ADDR_W), .N_PAIRS(N_PAIRS), .SPLIT(RD_SPLIT)) rd_gen (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .inc    (rd_fire),
        .wrap   (rd_wrap),
        .addr_a (ra_a),
        .addr_b (ra_b)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= ST_FILL;
            wr_bank      <= 1'b0;
            flush_pend   <= 1'b0;
            o_we_b0      <= 1'b0;
            o_we_b1      <= 1'b0;
            o_wr_addr_a  <= '0;
            o_wr_addr_b  <= '0;
            o_rd_addr_a  <= '0;
            o_rd_addr_b  <= '0;
            o_rd_bank    <= 1'b0;
            o_rd_strobe  <= 1'b0;
            o_frame_done <= 1'b0;
            o_drain_done <= 1'b0;
            o_err        <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_we_b0      <= wr_fire && !wr_bank;
            o_we_b1      <= wr_fire && wr_bank;
            o_rd_strobe  <= rd_fire;
            o_frame_done <= wr_fire && wr_wrap;
            o_drain_done <= state == ST_DRAIN && rd_wrap;
            o_err        <= o_err || (state == ST_DRAIN && i_wr_valid);
            if (wr_fire) begin
                o_wr_addr_a <= wa_a;
                o_wr_addr_b <= wa_b;
            end
            if (rd_fire) begin
                o_rd_addr_a <= ra_a;
                o_rd_addr_b <= ra_b;
                o_rd_bank   <= !wr_bank;
            end
            if (wr_fire && wr_wrap)
                wr_bank <= !wr_bank;
            // o_busy is computed for the state/count this edge produces.
            case (state)
                ST_FILL: begin
                    flush_pend <= 1'b0;
                    o_busy     <= wr_fire || !wr_zero;
                    if (wr_fire && wr_wrap)
                        state <= ST_STREAM;
                end
                ST_STREAM: begin
                    flush_pend <= flush_pend || i_flush;
                    o_busy     <= 1'b1;
                    if (flush_pend && wr_zero && !i_wr_valid)
                        state <= ST_DRAIN;
                end
                default: begin
                    // No writes happen in DRAIN, so the write count is already 0 here.
                    o_busy <= !rd_wrap;
                    if (rd_wrap) begin
                        state      <= ST_FILL;
                        flush_pend <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// tb_fft_pingpong_ctrl: randomized and directed check of the ping-pong sequencer against a frame-level model.
module tb_fft_pingpong_ctrl;

    localparam int AW = 10;
    localparam int NP = 512;
    localparam int WS = 2;
    localparam int RS = 3;
    localparam int FILL = 0, STREAM = 1, DRAIN = 2;

    logic          i_clk = 1'b0;
    logic          i_reset, i_wr_valid, i_flush;
    logic          o_we_b0, o_we_b1, o_rd_bank, o_rd_strobe;
    logic          o_frame_done, o_drain_done, o_err, o_busy;
    logic [AW-1:0] o_wr_addr_a, o_wr_addr_b, o_rd_addr_a, o_rd_addr_b;

    int n_cmp = 0, n_bad = 0;
    int m_st, m_wc, m_rc;
    bit m_bank, m_fp, m_err;
    int n_we0, n_we1, n_rs, n_fd, n_dd, n_coin, n_rb1;

    fft_pingpong_ctrl #(.ADDR_W(AW), .N_PAIRS(NP), .WR_SPLIT(WS), .RD_SPLIT(RS)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr_valid  (i_wr_valid),
        .i_flush     (i_flush),
        .o_we_b0     (o_we_b0),
        .o_we_b1     (o_we_b1),
        .o_wr_addr_a (o_wr_addr_a),
        .o_wr_addr_b (o_wr_addr_b),
        .o_rd_addr_a (o_rd_addr_a),
        .o_rd_addr_b (o_rd_addr_b),
        .o_rd_bank   (o_rd_bank),
        .o_rd_strobe (o_rd_strobe),
        .o_frame_done(o_frame_done),
        .o_drain_done(o_drain_done),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pair address: count with bit b spliced in at position s.
    function automatic int ins(int c, int s, int b);
        return (c / (2 ** s)) * (2 ** (s + 1)) + b * (2 ** s) + c % (2 ** s);
    endfunction

    // Observed outputs; addresses and read bank only matter when their enable/strobe is high.
    function automatic logic [47:0] outs();
        logic wen;
        wen = o_we_b0 | o_we_b1;
        return {o_we_b0, o_we_b1,
                wen ? o_wr_addr_a : '0, wen ? o_wr_addr_b : '0,
                o_rd_strobe ? o_rd_addr_a : '0, o_rd_strobe ? o_rd_addr_b : '0,
                o_rd_strobe & o_rd_bank, o_rd_strobe, o_frame_done, o_drain_done, o_err, o_busy};
    endfunction

    task automatic model_reset();
        m_st = FILL; m_wc = 0; m_rc = 0; m_bank = 0; m_fp = 0; m_err = 0;
    endtask

    task automatic clr_stats();
        n_we0 = 0; n_we1 = 0; n_rs = 0; n_fd = 0; n_dd = 0; n_coin = 0; n_rb1 = 0;
    endtask

    // One clock: apply inputs, predict the registered outputs, compare after the edge.
    task automatic step(input bit v, input bit f);
        bit e_we0, e_we1, e_rs, e_rbank, e_fd, e_dd, e_by;
        int e_wa, e_wb, e_ra, e_rb, st_n, pre_wc, pre_rc;
        logic [47:0] exp_v;
        e_we0 = 0; e_we1 = 0; e_rs = 0; e_rbank = 0; e_fd = 0; e_dd = 0;
        e_wa = 0; e_wb = 0; e_ra = 0; e_rb = 0;
        i_wr_valid = v;
        i_flush = f;
        st_n = m_st;
        pre_wc = m_wc;
        pre_rc = m_rc;
        if ((m_st == STREAM && v) || m_st == DRAIN) begin
            e_rs = 1; e_rbank = !m_bank;
            e_ra = ins(m_rc, RS, 0); e_rb = ins(m_rc, RS, 1);
            if (m_rc == NP - 1) begin
                m_rc = 0;
                if (m_st == DRAIN) begin e_dd = 1; st_n = FILL; m_fp = 0; end
            end else m_rc++;
        end
        if (v && m_st == DRAIN) m_err = 1;
        if (v && m_st != DRAIN) begin
            e_we0 = !m_bank; e_we1 = m_bank;
            e_wa = ins(m_wc, WS, 0); e_wb = ins(m_wc, WS, 1);
            if (m_wc == NP - 1) begin
                m_wc = 0; m_bank = !m_bank; e_fd = 1; st_n = STREAM;
            end else m_wc++;
        end
        if (m_st == FILL) m_fp = 0;
        else if (m_st == STREAM) begin
            if (m_fp && pre_wc == 0 && !v) st_n = DRAIN;
            m_fp = m_fp | f;
        end
        m_st = st_n;
        e_by = m_st != FILL || m_wc != 0;
        exp_v = {e_we0, e_we1, AW'(e_wa), AW'(e_wb), AW'(e_ra), AW'(e_rb),
                 e_rbank, e_rs, e_fd, e_dd, m_err, e_by};
        @(posedge i_clk);
        #1;
        chk("outs", 64'(outs()), 64'(exp_v));
        if ((e_we0 | e_we1) && pre_wc == 5)
            chk("wr_addr_cnt5", 64'({o_wr_addr_a, o_wr_addr_b}), 64'({10'd9, 10'd13}));
        if (e_rs && pre_rc == 9)
            chk("rd_addr_cnt9", 64'({o_rd_addr_a, o_rd_addr_b}), 64'({10'd17, 10'd25}));
        n_we0 += int'(o_we_b0);
        n_we1 += int'(o_we_b1);
        n_rs  += int'(o_rd_strobe);
        n_fd  += int'(o_frame_done);
        n_dd  += int'(o_drain_done);
        n_coin += int'(o_we_b1 != o_rd_strobe);
        n_rb1 += int'(o_rd_strobe && o_rd_bank);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        bit done;
        i_reset = 1'b0; i_wr_valid = 1'b0; i_flush = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_outs", 64'(outs()), 64'd0);
        i_reset = 1'b1;

        // Frame 1: back-to-back valids fill bank 0, no reads.
        clr_stats();
        repeat (NP) step(1'b1, 1'b0);
        chk("fill_we0", 64'(n_we0), 64'(NP));
        chk("fill_we1", 64'(n_we1), 64'd0);
        chk("fill_rd", 64'(n_rs), 64'd0);
        chk("fill_frame_done", 64'(n_fd), 64'd1);

        // Frame 2: one valid in three, flush requested together with write 100.
        clr_stats();
        for (int i = 0; i < NP; i++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b1, i == 100);
        end
        chk("strm_we1", 64'(n_we1), 64'(NP));
        chk("strm_we0", 64'(n_we0), 64'd0);
        chk("strm_rd", 64'(n_rs), 64'(NP));
        chk("strm_coincide", 64'(n_coin), 64'd0);
        chk("strm_rd_bank1", 64'(n_rb1), 64'd0);
        chk("strm_drain_done", 64'(n_dd), 64'd0);

        // Drain bank 1 with no input; one stray valid along the way.
        clr_stats();
        step(1'b0, 1'b0);
        len = 0;
        done = 0;
        while (!done && len < 600) begin
            step(len == 50, 1'b0);
            len++;
            done = o_drain_done;
        end
        chk("drain_finished", 64'(done), 64'd1);
        chk("drain_len", 64'(len), 64'(NP));
        chk("drain_rd", 64'(n_rs), 64'(NP));
        chk("drain_rd_bank1", 64'(n_rb1), 64'(NP));
        chk("drain_done_cnt", 64'(n_dd), 64'd1);
        chk("drain_no_we", 64'(n_we0 + n_we1), 64'd0);
        chk("drain_err", 64'(o_err), 64'd1);
        step(1'b0, 1'b0);

        // Random traffic with occasional flushes.
        repeat (1500) step(1'(($urandom & 3) != 0), 1'($urandom_range(0, 299) == 0));
        len = 0;
        while (m_st != STREAM && len < 2000) begin
            step(1'($urandom & 1), 1'b0);
            len++;
        end
        repeat (7) step(1'($urandom & 1), 1'b0);

        // Reset in the middle of operation.
        i_reset = 1'b0;
        i_wr_valid = 1'b0;
        i_flush = 1'b0;
        #1;
        chk("reset_mid", 64'(outs()), 64'd0);
        model_reset();
        @(posedge i_clk);
        #1;
        chk("reset_hold", 64'(outs()), 64'd0);
        i_reset = 1'b1;

        repeat (3000) step(1'($urandom & 1), 1'($urandom_range(0, 199) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
